// File: rtl/array_multiplier.sv
// Unsigned 6x6 array multiplier: AND-gate partial products reduced by rows of
// ripple adders, with the 12-bit product captured in a register every cycle.

module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b;
    assign o_cout = i_a & i_b;
endmodule

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
endmodule

module array_multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  a,
    input  logic [5:0]  b,
    output logic [11:0] m
);
    logic [5:0][5:0] w_pp;
    logic [5:0][5:0] w_sum;
    logic [5:1][5:0] w_carry;
    logic [5:1]      w_cout;
    logic [11:0]     w_product;
    logic [11:0]     r_m;

    genvar gi, gj;

    generate
        for (gi = 0; gi < 6; gi++) begin : g_ppRow
            for (gj = 0; gj < 6; gj++) begin : g_ppCol
                assign w_pp[gi][gj] = a[gj] & b[gi];
            end
        end
    endgenerate

    assign w_sum[0] = w_pp[0];

    // Row i adds its partial products to the previous row shifted right by one:
    // bit j sees sum[i-1][j+1], and the top bit sees the previous row's carry-out.
    generate
        for (gi = 1; gi < 6; gi++) begin : g_row
            half_adder u_ha0 (
                .i_a    (w_pp[gi][0]),
                .i_b    (w_sum[gi-1][1]),
                .o_sum  (w_sum[gi][0]),
                .o_cout (w_carry[gi][0])
            );

            for (gj = 1; gj < 5; gj++) begin : g_mid
                full_adder u_fa (
                    .i_a    (w_pp[gi][gj]),
                    .i_b    (w_sum[gi-1][gj+1]),
                    .i_cin  (w_carry[gi][gj-1]),
                    .o_sum  (w_sum[gi][gj]),
                    .o_cout (w_carry[gi][gj])
                );
            end

            // Row 0 has no carry-out, so the first row's top cell has only two inputs.
            if (gi == 1) begin : g_topHa
                half_adder u_ha5 (
                    .i_a    (w_pp[gi][5]),
                    .i_b    (w_carry[gi][4]),
                    .o_sum  (w_sum[gi][5]),
                    .o_cout (w_carry[gi][5])
                );
            end else begin : g_topFa
                full_adder u_fa5 (
                    .i_a    (w_pp[gi][5]),
                    .i_b    (w_cout[gi-1]),
                    .i_cin  (w_carry[gi][4]),
                    .o_sum  (w_sum[gi][5]),
                    .o_cout (w_carry[gi][5])
                );
            end

            assign w_cout[gi] = w_carry[gi][5];
        end
    endgenerate

    generate
        for (gi = 0; gi < 5; gi++) begin : g_lowBits
            assign w_product[gi] = w_sum[gi][0];
        end
    endgenerate

    assign w_product[10:5] = w_sum[5];
    assign w_product[11]   = w_cout[5];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m <= 12'd0;
        end else begin
            r_m <= w_product;
        end
    end

    assign m = r_m;

endmodule

// File: tb/tb_array_multiplier.sv
// Scoreboard bench for array_multiplier: stimulus pushes expected products,
// a monitor pops and compares one result per cycle on the falling edge.

module tb_array_multiplier;

    typedef struct {
        string      name;
        logic [5:0] opA;
        logic [5:0] opB;
        logic [11:0] expected;
    } expect_t;

    logic        clk;
    logic        rst;
    logic [5:0]  a;
    logic [5:0]  b;
    logic [11:0] m;

    expect_t scoreboard[$];
    int checkCount;
    int errorCount;

    array_multiplier dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .m   (m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer multiplication, or zero when reset wins.
    function automatic logic [11:0] refProduct(input logic doReset, input logic [5:0] x, input logic [5:0] y);
        int prod;
        prod = int'(x) * int'(y);
        return doReset ? 12'd0 : prod[11:0];
    endfunction

    task automatic applyStimulus(input string name, input logic doReset, input logic [5:0] x, input logic [5:0] y);
        expect_t e;
        @(negedge clk);
        rst = doReset;
        a   = x;
        b   = y;
        @(posedge clk);
        e.name     = name;
        e.opA      = x;
        e.opB      = y;
        e.expected = refProduct(doReset, x, y);
        scoreboard.push_back(e);
    endtask

    task automatic checkOutput(input expect_t e);
        checkCount++;
        if (m !== e.expected) begin
            errorCount++;
            $display("[TB] FAIL %s a=%0d b=%0d got=%0d expected=%0d", e.name, e.opA, e.opB, m, e.expected);
        end
    endtask

    // Monitor: each falling edge shows the result of the preceding rising edge.
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (scoreboard.size() > 0) begin
                e = scoreboard.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst = 1'b1;
        a   = 6'd5;
        b   = 6'd4;

        applyStimulus("reset0", 1'b1, 6'd5, 6'd4);
        applyStimulus("reset1", 1'b1, 6'd5, 6'd4);
        applyStimulus("postReset", 1'b0, 6'd5, 6'd4);

        applyStimulus("zero", 1'b0, 6'd0, 6'd0);
        applyStimulus("fiveFour", 1'b0, 6'd5, 6'd4);
        applyStimulus("directed736", 1'b0, 6'd32, 6'd23);
        applyStimulus("maxMax", 1'b0, 6'd63, 6'd63);
        applyStimulus("maxOne", 1'b0, 6'd63, 6'd1);
        applyStimulus("oneMax", 1'b0, 6'd1, 6'd63);
        applyStimulus("zeroMax", 1'b0, 6'd0, 6'd63);

        for (int i = 0; i < 10; i++) begin
            applyStimulus("stream", 1'b0, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
        end

        for (int i = 0; i < 3; i++) begin
            applyStimulus("preReset", 1'b0, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
        end
        applyStimulus("midReset", 1'b1, 6'($urandom_range(1, 63)), 6'($urandom_range(1, 63)));
        applyStimulus("afterReset", 1'b0, 6'($urandom_range(1, 63)), 6'($urandom_range(1, 63)));
        for (int i = 0; i < 3; i++) begin
            applyStimulus("postStream", 1'b0, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
        end

        for (int x = 0; x < 64; x++) begin
            for (int y = 0; y < 64; y++) begin
                applyStimulus("exhaustive", 1'b0, 6'(x), 6'(y));
            end
        end

        for (int i = 0; i < 5 && scoreboard.size() > 0; i++) begin
            @(negedge clk);
        end
        @(posedge clk);
        checkCount++;
        if (scoreboard.size() != 0) begin
            errorCount++;
            $display("[TB] FAIL drain pending=%0d expected=0", scoreboard.size());
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
